// File: rtl/fetch_pc_gen_if.sv
// Fetch request channel between the PC generator and the I-cache front end.
// The generator drives the request and its decode; the cache returns ready.
interface fetch_pc_gen_if #(
    parameter int FETCH_WIDTH = 1
);
    logic                   req_valid_o;
    logic                   req_ready_i;
    logic [31:0]            pc_o;
    logic [FETCH_WIDTH-1:0] fetch_mask_o;
    logic [31:0]            exception_type_o;

    modport master (
        output req_valid_o,
        output pc_o,
        output fetch_mask_o,
        output exception_type_o,
        input  req_ready_i
    );

    modport slave (
        input  req_valid_o,
        input  pc_o,
        input  fetch_mask_o,
        input  exception_type_o,
        output req_ready_i
    );
endinterface

// File: rtl/fetch_pc_gen.sv
// IF-stage fetch PC generator: issues pc_o over a valid/ready request. Redirects land 1 cycle after sampling.
// PC holds under stall or !ready; a branch seen while held is latched and applied on the next advance.
module fetch_pc_gen #(
    parameter logic [31:0] RESET_PC    = 32'hbfc0_0000,
    parameter int          FETCH_WIDTH = 1,
    parameter int          STALL_WIDTH = 4
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic [STALL_WIDTH-1:0] stall_i,
    input  logic                   exception_i,
    input  logic [31:0]            exception_pc_i,
    input  logic                   branch_enable_i,
    input  logic [31:0]            branch_addr_i,
    output logic                   redirect_pending_o,
    fetch_pc_gen_if.master         req
);
    localparam int          BLK       = $clog2(4 * FETCH_WIDTH);
    localparam logic [31:0] BLK_BYTES = 32'(4 * FETCH_WIDTH);

    logic [31:0] pc_q;
    logic        vld_q;
    logic        pend_vld_q;
    logic [31:0] pend_addr_q;
    logic        adv;
    logic [31:0] blk_base;

    assign adv      = vld_q & req.req_ready_i & ~|stall_i;
    assign blk_base = pc_q & ~(BLK_BYTES - 32'd1);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            pc_q        <= RESET_PC;
            vld_q       <= 1'b0;
            pend_vld_q  <= 1'b0;
            pend_addr_q <= 32'd0;
        end else begin
            vld_q <= 1'b1;
            if (exception_i) begin
                // Aborts any outstanding request and drops a same-cycle or pending branch.
                pc_q       <= exception_pc_i;
                pend_vld_q <= 1'b0;
            end else if (branch_enable_i && adv) begin
                pc_q       <= branch_addr_i;
                pend_vld_q <= 1'b0;
            end else if (branch_enable_i) begin
                pend_addr_q <= branch_addr_i;
                pend_vld_q  <= 1'b1;
            end else if (pend_vld_q && adv) begin
                pc_q       <= pend_addr_q;
                pend_vld_q <= 1'b0;
            end else if (adv) begin
                pc_q <= blk_base + BLK_BYTES;
            end
        end
    end

    generate
        if (FETCH_WIDTH == 1) begin : g_mask_single
            assign req.fetch_mask_o = 1'b1;
        end else begin : g_mask_multi
            logic [BLK-3:0]         slot;
            logic [FETCH_WIDTH-1:0] mask;
            assign slot = pc_q[BLK-1:2];
            always_comb begin
                mask = '0;
                for (int i = 0; i < FETCH_WIDTH; i++) begin
                    mask[i] = (i >= int'(slot));
                end
            end
            assign req.fetch_mask_o = mask;
        end
    endgenerate

    assign req.req_valid_o      = vld_q;
    assign req.pc_o             = pc_q;
    assign req.exception_type_o = (pc_q[1:0] == 2'b00) ? 32'd0 : 32'h8000_0000;
    assign redirect_pending_o   = pend_vld_q;
endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen at FETCH_WIDTH 1 and 4, with a queue of expected states.
module tb_fetch_pc_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // FETCH_WIDTH=1 instance
    logic        rst1, exc1, br1;
    logic [3:0]  stall1;
    logic [31:0] exc_pc1, br_addr1;
    logic        pend1;
    fetch_pc_gen_if #(.FETCH_WIDTH(1)) r1 ();

    fetch_pc_gen #(.RESET_PC(32'hbfc0_0000), .FETCH_WIDTH(1), .STALL_WIDTH(4)) dut1 (
        .clock_i(clk), .reset_i(rst1), .stall_i(stall1), .exception_i(exc1),
        .exception_pc_i(exc_pc1), .branch_enable_i(br1), .branch_addr_i(br_addr1),
        .redirect_pending_o(pend1), .req(r1)
    );

    // FETCH_WIDTH=4 instance
    logic        rst4, br4;
    logic [31:0] br_addr4;
    logic        pend4;
    fetch_pc_gen_if #(.FETCH_WIDTH(4)) r4 ();

    fetch_pc_gen #(.RESET_PC(32'hbfc0_0000), .FETCH_WIDTH(4), .STALL_WIDTH(4)) dut4 (
        .clock_i(clk), .reset_i(rst4), .stall_i(4'b0000), .exception_i(1'b0),
        .exception_pc_i(32'd0), .branch_enable_i(br4), .branch_addr_i(br_addr4),
        .redirect_pending_o(pend4), .req(r4)
    );

    typedef struct {
        string       tag;
        int          dut;
        logic [31:0] pc;
        logic        vld;
        logic        pend;
        logic [3:0]  mask;
        logic [31:0] etype;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Queue the state expected after the next edge, clock it, then pop and compare.
    task automatic step(input string tag, input int dut, input logic [31:0] pc,
                        input logic vld, input logic pend, input logic [3:0] mask);
        exp_t e;
        e.tag   = tag;
        e.dut   = dut;
        e.pc    = pc;
        e.vld   = vld;
        e.pend  = pend;
        e.mask  = mask;
        e.etype = (pc[1:0] == 2'b00) ? 32'd0 : 32'h8000_0000;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        if (e.dut == 1) begin
            cmp({e.tag, ".pc"},    r1.pc_o, e.pc);
            cmp({e.tag, ".vld"},   32'(r1.req_valid_o), 32'(e.vld));
            cmp({e.tag, ".pend"},  32'(pend1), 32'(e.pend));
            cmp({e.tag, ".mask"},  32'(r1.fetch_mask_o), 32'(e.mask[0]));
            cmp({e.tag, ".etype"}, r1.exception_type_o, e.etype);
        end else begin
            cmp({e.tag, ".pc"},    r4.pc_o, e.pc);
            cmp({e.tag, ".vld"},   32'(r4.req_valid_o), 32'(e.vld));
            cmp({e.tag, ".pend"},  32'(pend4), 32'(e.pend));
            cmp({e.tag, ".mask"},  32'(r4.fetch_mask_o), 32'(e.mask));
            cmp({e.tag, ".etype"}, r4.exception_type_o, e.etype);
        end
    endtask

    initial begin
        rst1 = 1'b1; exc1 = 1'b0; br1 = 1'b0; stall1 = 4'b0;
        exc_pc1 = 32'd0; br_addr1 = 32'd0; r1.req_ready_i = 1'b1;
        rst4 = 1'b1; br4 = 1'b0; br_addr4 = 32'd0; r4.req_ready_i = 1'b1;

        // Reset and sequential start
        step("rst0", 1, 32'hbfc0_0000, 1'b0, 1'b0, 4'b0001);
        step("rst1", 1, 32'hbfc0_0000, 1'b0, 1'b0, 4'b0001);
        rst1 = 1'b0;
        step("vld_up", 1, 32'hbfc0_0000, 1'b1, 1'b0, 4'b0001);
        step("seq1",   1, 32'hbfc0_0004, 1'b1, 1'b0, 4'b0001);
        step("seq2",   1, 32'hbfc0_0008, 1'b1, 1'b0, 4'b0001);

        // Branch arriving during stall is latched, then applied
        stall1 = 4'b0010; br1 = 1'b1; br_addr1 = 32'h8000_1000;
        step("stbr_lat", 1, 32'hbfc0_0008, 1'b1, 1'b1, 4'b0001);
        br1 = 1'b0;
        step("stbr_hold", 1, 32'hbfc0_0008, 1'b1, 1'b1, 4'b0001);
        stall1 = 4'b0000;
        step("stbr_apply", 1, 32'h8000_1000, 1'b1, 1'b0, 4'b0001);

        // Exception beats same-cycle branch and clears pending, even with ready low
        stall1 = 4'b0001; br1 = 1'b1; br_addr1 = 32'h8000_2000;
        step("exc_pend", 1, 32'h8000_1000, 1'b1, 1'b1, 4'b0001);
        stall1 = 4'b0000; r1.req_ready_i = 1'b0;
        exc1 = 1'b1; exc_pc1 = 32'hbfc0_0380; br_addr1 = 32'h8000_3000;
        step("exc_win", 1, 32'hbfc0_0380, 1'b1, 1'b0, 4'b0001);
        exc1 = 1'b0; br1 = 1'b0;

        // Ready held low: hold, then exactly one advance
        step("rdy_lo0", 1, 32'hbfc0_0380, 1'b1, 1'b0, 4'b0001);
        step("rdy_lo1", 1, 32'hbfc0_0380, 1'b1, 1'b0, 4'b0001);
        step("rdy_lo2", 1, 32'hbfc0_0380, 1'b1, 1'b0, 4'b0001);
        r1.req_ready_i = 1'b1;
        step("rdy_hi", 1, 32'hbfc0_0384, 1'b1, 1'b0, 4'b0001);
        r1.req_ready_i = 1'b0;
        step("rdy_once", 1, 32'hbfc0_0384, 1'b1, 1'b0, 4'b0001);

        // Misaligned target flags exception_type and realigns on advance
        r1.req_ready_i = 1'b1; br1 = 1'b1; br_addr1 = 32'h8000_0002;
        step("mis_br", 1, 32'h8000_0002, 1'b1, 1'b0, 4'b0001);
        br1 = 1'b0;
        step("mis_seq", 1, 32'h8000_0004, 1'b1, 1'b0, 4'b0001);

        // Address wrap
        br1 = 1'b1; br_addr1 = 32'hffff_fffc;
        step("wrap_br", 1, 32'hffff_fffc, 1'b1, 1'b0, 4'b0001);
        br1 = 1'b0;
        step("wrap_seq", 1, 32'h0000_0000, 1'b1, 1'b0, 4'b0001);

        // Reset mid-operation discards a pending branch
        stall1 = 4'b1000; br1 = 1'b1; br_addr1 = 32'h1234_5678;
        step("mid_pend", 1, 32'h0000_0000, 1'b1, 1'b1, 4'b0001);
        br1 = 1'b0; rst1 = 1'b1;
        step("mid_rst", 1, 32'hbfc0_0000, 1'b0, 1'b0, 4'b0001);
        rst1 = 1'b0; stall1 = 4'b0000;
        step("mid_rel", 1, 32'hbfc0_0000, 1'b1, 1'b0, 4'b0001);

        // FETCH_WIDTH=4: partial mask on mid-block target, then block-aligned advance
        step("w4_rst", 4, 32'hbfc0_0000, 1'b0, 1'b0, 4'b1111);
        rst4 = 1'b0;
        step("w4_vld", 4, 32'hbfc0_0000, 1'b1, 1'b0, 4'b1111);
        br4 = 1'b1; br_addr4 = 32'h8000_0008;
        step("w4_br", 4, 32'h8000_0008, 1'b1, 1'b0, 4'b1100);
        br4 = 1'b0;
        step("w4_seq1", 4, 32'h8000_0010, 1'b1, 1'b0, 4'b1111);
        step("w4_seq2", 4, 32'h8000_0020, 1'b1, 1'b0, 4'b1111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
